mcp_tx_scheduler: RTL and testbench



---
 rtl/mcp_sched_pkg.sv | 26 ++
 rtl/mcp_tx_scheduler_rr_arbiter.sv | 32 +++
 rtl/mcp_tx_scheduler.sv | 104 ++++++++++
 tb/tb_mcp_tx_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_sched_pkg.sv
// Shared types and constants for the MCP transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcp_sched_pkg;

    localparam int UART_WIDTH = 64;
    localparam int PAYLOAD_W  = UART_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Packet-type codes used by stimulus generators.
    localparam logic [1:0] DATA      = 2'd0;
    localparam logic [1:0] TEST      = 2'd1;
    localparam logic [1:0] CFG_WRITE = 2'd2;
    localparam logic [1:0] CFG_READ  = 2'd3;

    function automatic logic odd_parity(input logic [PAYLOAD_W-1:0] payload);
        return ~^payload;
    endfunction

endpackage

// File: rtl/mcp_tx_scheduler_rr_arbiter.sv
// Round-robin priority rotate: first asserted request at or after ptr wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mcp_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ requesters; appends odd parity to the granted payload.
// Latency: req_ready same cycle as req_valid in IDLE, ld_tx_data the next cycle.
// Backpressure: holds ld_tx_data until tx_busy rises (bounded by BUSY_TIMEOUT), then waits for tx_busy to fall plus GAP_CYCLES.
module mcp_tx_scheduler
    import mcp_sched_pkg::*;
#(
    parameter  int WIDTH        = 64,
    parameter  int NUM_REQ      = 4,
    parameter  int GAP_CYCLES   = 2,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int PW           = WIDTH - 1,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*PW-1:0] req_packet,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [WIDTH-1:0]      tx_data,
    output logic                  ld_tx_data,
    input  logic                  tx_busy,
    output logic [IDX_W-1:0]      grant_id,
    output logic [15:0]           sent_count,
    output logic                  timeout_err
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // With no gap configured the packet epilogue returns straight to IDLE.
    localparam state_t AFTER_TX = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic [PW-1:0]     grant_pkt;
    logic              load_expired;
    logic              gap_done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign grant_pkt    = req_packet[int'(arb_idx)*PW +: PW];
    assign load_expired = (cnt == CNT_W'(BUSY_TIMEOUT - 1));
    assign gap_done     = (cnt == CNT_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (|req_valid) state_nxt = LOAD;
            LOAD: begin
                if (tx_busy)           state_nxt = WAIT_DONE;
                else if (load_expired) state_nxt = AFTER_TX;
            end
            WAIT_DONE: if (!tx_busy)   state_nxt = AFTER_TX;
            GAP:       if (gap_done)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_tx_data = (state == LOAD);
        req_ready  = (state == IDLE && reset_n) ? arb_grant : '0;
    end

    // cnt restarts on every state change, so it always measures time spent in the current state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_data     <= '0;
            grant_id    <= '0;
            ptr         <= '0;
            cnt         <= '0;
            sent_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            cnt         <= (state != state_nxt) ? '0 : cnt + CNT_W'(1);
            case (state)
                IDLE: if (|req_valid) begin
                    tx_data  <= {~^grant_pkt, grant_pkt};
                    grant_id <= arb_idx;
                    ptr      <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                end
                LOAD:      if (!tx_busy && load_expired) timeout_err <= 1'b1;
                WAIT_DONE: if (!tx_busy) sent_count <= sent_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_tx_scheduler.sv
// Directed bench for mcp_tx_scheduler: reset, grant/parity, fairness, gap, timeout, wrap.
// Latency: n/a.
// Backpressure: tx_busy is driven by hand-written handshake tasks.
module tb_mcp_tx_scheduler;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    req_valid;
    logic [251:0]  req_packet;
    logic [3:0]    req_ready;
    logic [63:0]   tx_data;
    logic          ld_tx_data;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic [15:0]   sent_count;
    logic          timeout_err;

    int n_chk = 0;
    int n_bad = 0;

    mcp_tx_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_packet  (req_packet),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .ld_tx_data  (ld_tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .sent_count  (sent_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ld(input string tag);
        int n = 0;
        while (!ld_tx_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ld_seen"}, 64'(ld_tx_data), 64'd1);
    endtask

    // Raise tx_busy after dly edges, hold it for len edges, then drop it.
    task automatic serve(input int dly, input int len);
        repeat (dly) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
    endtask

    task automatic send_one(input int idx, input logic [62:0] pl, input logic [63:0] exp, input string tag);
        req_packet = '0;
        req_packet[idx*63 +: 63] = pl;
        req_valid = 4'b0001 << idx;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(req_ready), 64'(4'b0001 << idx));
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check({tag, "_rdy_off"}, 64'(req_ready), 64'd0);
        check({tag, "_ld"}, 64'(ld_tx_data), 64'd1);
        check({tag, "_data"}, tx_data, exp);
        check({tag, "_gid"}, 64'(grant_id), 64'(idx));
        serve(2, 3);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, n_ld, n_to, n_rdy;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_packet = '0;
        tx_busy    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ld", 64'(ld_tx_data), 64'd0);
        check("rst_rdy", 64'(req_ready), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);
        check("rst_sent", 64'(sent_count), 64'd0);
        check("rst_to", 64'(timeout_err), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester and parity
        send_one(2, 63'h0, 64'h8000_0000_0000_0000, "single");
        check("single_sent", 64'(sent_count), 64'd1);
        send_one(0, 63'h1, 64'h0000_0000_0000_0001, "par1");
        send_one(3, 63'h3, 64'h8000_0000_0000_0003, "par3");
        check("par_sent", 64'(sent_count), 64'd3);

        // Fairness with all requesters asserted, gap measured in clock edges
        req_packet = '0;
        req_valid  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_ld("fair");
            check($sformatf("fair_gid%0d", k), 64'(grant_id), 64'(k % 4));
            serve(1, 3);
            if (k < 7) begin
                @(posedge clk);
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!ld_tx_data && n < 20);
                check($sformatf("fair_gap%0d", k), 64'(n), 64'd3);
            end else begin
                req_valid = '0;
            end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("fair_sent", 64'(sent_count), 64'd11);

        // Timeout: tx_busy never rises for the first grant
        req_valid = 4'b0011;
        wait_ld("to");
        check("to_gid", 64'(grant_id), 64'd0);
        n_ld = 0;
        n_to = 0;
        while (ld_tx_data && n_ld < 40) begin
            n_ld++;
            @(negedge clk);
            if (timeout_err) n_to++;
        end
        repeat (3) begin
            @(negedge clk);
            if (timeout_err) n_to++;
        end
        check("to_ld_len", 64'(n_ld), 64'd16);
        check("to_pulse", 64'(n_to), 64'd1);
        check("to_sent", 64'(sent_count), 64'd11);
        check("to_next_ld", 64'(ld_tx_data), 64'd1);
        check("to_next_gid", 64'(grant_id), 64'd1);
        req_valid = '0;
        serve(0, 2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("to_after_sent", 64'(sent_count), 64'd12);

        // tx_busy high while idle is ignored; already high on LOAD entry
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_ld", 64'(ld_tx_data), 64'd0);
        check("glitch_sent", 64'(sent_count), 64'd12);
        req_packet = '0;
        req_packet[2*63 +: 63] = 63'h5;
        req_valid = 4'b0100;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("early_ld", 64'(ld_tx_data), 64'd1);
        check("early_data", tx_data, 64'h8000_0000_0000_0005);
        @(negedge clk);
        check("early_ld_one", 64'(ld_tx_data), 64'd0);
        @(posedge clk);
        #1 tx_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("early_sent", 64'(sent_count), 64'd13);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of LOAD
        req_valid = 4'b1000;
        @(posedge clk);
        #1;
        check("rst2_pre_ld", 64'(ld_tx_data), 64'd1);
        reset_n = 1'b0;
        n_rdy = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (req_ready !== 4'b0000) n_rdy++;
        end
        check("rst2_ld", 64'(ld_tx_data), 64'd0);
        check("rst2_sent", 64'(sent_count), 64'd0);
        check("rst2_data", tx_data, 64'd0);
        check("rst2_rdy_pulses", 64'(n_rdy), 64'd0);
        reset_n   = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("rst2_idle_ld", 64'(ld_tx_data), 64'd0);

        // Counter wrap
        force dut.sent_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.sent_count;
        @(negedge clk);
        check("wrap_pre", 64'(sent_count), 64'h0000_0000_0000_FFFF);
        req_packet = '0;
        req_packet[62:0] = {63{1'b1}};
        req_valid = 4'b0001;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("wrap_data", tx_data, 64'h7FFF_FFFF_FFFF_FFFF);
        check("wrap_gid", 64'(grant_id), 64'd0);
        serve(1, 2);
        @(posedge clk);
        @(negedge clk);
        check("wrap_sent", 64'(sent_count), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
